// File: rtl/mem_seq_pkg.sv
// ============================================================================
// Module  : mem_seq_pkg
// Brief   : Op codes, FSM encoding and per-op word counts for mem_access_sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_seq_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_PUSH  = 4'd3;
    localparam logic [3:0] OP_POP   = 4'd4;
    localparam logic [3:0] OP_CALL  = 4'd5;
    localparam logic [3:0] OP_RET   = 4'd6;
    localparam logic [3:0] OP_INT   = 4'd7;
    localparam logic [3:0] OP_RTI   = 4'd8;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PUSH_SEQ = 2'd1;
    localparam logic [1:0] ST_POP_SEQ  = 2'd2;
    localparam logic [1:0] ST_DRAIN    = 2'd3;

    function automatic logic [1:0] op_words(input logic [3:0] op);
        case (op)
            OP_CALL, OP_RET: op_words = 2'd2;
            OP_INT,  OP_RTI: op_words = 2'd3;
            default:         op_words = 2'd1;
        endcase
    endfunction

    function automatic logic is_push_op(input logic [3:0] op);
        is_push_op = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

    function automatic logic is_pop_op(input logic [3:0] op);
        is_pop_op = (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_seq_stack_guard.sv
// ============================================================================
// Module  : mem_seq_stack_guard
// Brief   : Stack depth tracker; suppresses ops that would over/underflow.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_seq_stack_guard #(
    parameter int STACK_DEPTH = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] push_req_words,
    input  logic [1:0] pop_req_words,
    output logic       suppress,
    output logic       stack_err
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;

    always_comb begin
        suppress = 1'b0;
        if ((push_req_words != 2'd0) &&
            ((32'(depth_q) + 32'(push_req_words)) > 32'(STACK_DEPTH)))
            suppress = 1'b1;
        if ((pop_req_words != 2'd0) && (32'(depth_q) < 32'(pop_req_words)))
            suppress = 1'b1;

        depth_d = depth_q;
        if (push)
            depth_d = depth_q + 1'b1;
        else if (pop)
            depth_d = depth_q - 1'b1;

        err_d = err_q | suppress;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign stack_err = err_q;

endmodule

`default_nettype wire

// File: rtl/mem_access_sequencer.sv
// ============================================================================
// Module  : mem_access_sequencer
// Brief   : Sequences pipeline memory ops into memory-stage strobes; splits
//           CALL/RET/INT/RTI into word transfers. Optional: MEM_SEQ_STACK_GUARD_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int PC_W        = 32,
    parameter int FLAG_W      = 3,
    parameter int STACK_DEPTH = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [PC_W-1:0]   op_pc,
    input  logic [FLAG_W-1:0] op_flags,
    input  logic [DATA_W-1:0] data_r,
    output logic              memory_read,
    output logic              memory_write,
    output logic              memory_push,
    output logic              memory_pop,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              stall,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              pc_valid,
    output logic [PC_W-1:0]   ret_pc,
    output logic              flags_valid,
    output logic [FLAG_W-1:0] ret_flags,
    output logic              stack_err
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0]        kind_q, kind_d;
    // lo_q holds the PC low word: captured from op_pc on push ops, from data_r on pops.
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              load_pend_q, load_pend_d;

    logic [1:0]        push_req_words;
    logic [1:0]        pop_req_words;
    logic              suppress;

    always_comb begin
        push_req_words = 2'd0;
        pop_req_words  = 2'd0;
        if (state_q == ST_IDLE) begin
            if (is_push_op(op)) push_req_words = op_words(op);
            if (is_pop_op(op))  pop_req_words  = op_words(op);
        end
    end

`ifdef MEM_SEQ_STACK_GUARD_EN
    mem_seq_stack_guard #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack_guard (
        .clk            (clk),
        .reset          (reset),
        .push           (memory_push),
        .pop            (memory_pop),
        .push_req_words (push_req_words),
        .pop_req_words  (pop_req_words),
        .suppress       (suppress),
        .stack_err      (stack_err)
    );
`else
    assign suppress  = 1'b0;
    // Tied low; the comparison only keeps the depth parameter referenced.
    assign stack_err = (STACK_DEPTH < 0);
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        kind_d       = kind_q;
        lo_d         = lo_q;
        flags_d      = flags_q;
        load_pend_d  = 1'b0;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        memory_push  = 1'b0;
        memory_pop   = 1'b0;
        address      = '0;
        write_data   = '0;
        stall        = 1'b0;
        pc_valid     = 1'b0;
        flags_valid  = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (!suppress) begin
                        case (op)
                            OP_LOAD: begin
                                memory_read = 1'b1;
                                address     = op_addr;
                                load_pend_d = 1'b1;
                            end
                            OP_STORE: begin
                                memory_write = 1'b1;
                                address      = op_addr;
                                write_data   = op_wdata;
                            end
                            OP_PUSH: begin
                                memory_push = 1'b1;
                                write_data  = op_wdata;
                            end
                            OP_POP: begin
                                memory_pop  = 1'b1;
                                load_pend_d = 1'b1;
                            end
                            OP_CALL, OP_INT: begin
                                memory_push = 1'b1;
                                write_data  = op_pc[PC_W-1:DATA_W];
                                stall       = 1'b1;
                                state_d     = ST_PUSH_SEQ;
                                cnt_d       = 2'd1;
                                kind_d      = op;
                                lo_d        = op_pc[DATA_W-1:0];
                                flags_d     = op_flags;
                            end
                            OP_RET, OP_RTI: begin
                                memory_pop = 1'b1;
                                stall      = 1'b1;
                                state_d    = ST_POP_SEQ;
                                cnt_d      = 2'd1;
                                kind_d     = op;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_PUSH_SEQ: begin
                    memory_push = 1'b1;
                    if (cnt_q == 2'd1) begin
                        write_data = lo_q;
                        if (kind_q == OP_INT) begin
                            stall = 1'b1;
                            cnt_d = 2'd2;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = 2'd0;
                        end
                    end else begin
                        write_data = {{(DATA_W-FLAG_W){1'b0}}, flags_q};
                        state_d    = ST_IDLE;
                        cnt_d      = 2'd0;
                    end
                end

                ST_POP_SEQ: begin
                    memory_pop = 1'b1;
                    stall      = 1'b1;
                    // RTI pops flags first, so its first returned word is the flags.
                    if ((cnt_q == 2'd1) && (kind_q == OP_RTI)) begin
                        flags_d = data_r[FLAG_W-1:0];
                        cnt_d   = 2'd2;
                    end else begin
                        lo_d    = data_r;
                        state_d = ST_DRAIN;
                        cnt_d   = 2'd0;
                    end
                end

                default: begin
                    pc_valid    = 1'b1;
                    flags_valid = (kind_q == OP_RTI);
                    state_d     = ST_IDLE;
                    cnt_d       = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            kind_q      <= OP_NONE;
            lo_q        <= '0;
            flags_q     <= '0;
            load_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
            lo_q        <= lo_d;
            flags_q     <= flags_d;
            load_pend_q <= load_pend_d;
        end
    end

    assign load_valid = load_pend_q & ~reset;
    assign load_data  = data_r;
    assign ret_pc     = pc_valid ? {data_r, lo_q} : '0;
    assign ret_flags  = flags_valid ? flags_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
// ============================================================================
// Module  : tb_mem_access_sequencer
// Brief   : Directed self-checking bench for mem_access_sequencer with a small
//           memory-stage model. Guard scenario runs with MEM_SEQ_STACK_GUARD_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_sequencer;

`ifdef MEM_SEQ_STACK_GUARD_EN
    localparam int C_DEPTH = 2;
`else
    localparam int C_DEPTH = 2048;
`endif

    // Status vector bits: {read, write, push, pop, stall, load_valid, pc_valid, flags_valid}
    localparam logic [7:0] V_RD = 8'h80;
    localparam logic [7:0] V_WR = 8'h40;
    localparam logic [7:0] V_PU = 8'h20;
    localparam logic [7:0] V_PO = 8'h10;
    localparam logic [7:0] V_ST = 8'h08;
    localparam logic [7:0] V_LV = 8'h04;
    localparam logic [7:0] V_PC = 8'h02;
    localparam logic [7:0] V_FV = 8'h01;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [15:0] op_addr;
    logic [15:0] op_wdata;
    logic [31:0] op_pc;
    logic [2:0]  op_flags;
    logic [15:0] data_r;
    logic        memory_read, memory_write, memory_push, memory_pop;
    logic [15:0] address;
    logic [15:0] write_data;
    logic        stall, load_valid, pc_valid, flags_valid, stack_err;
    logic [15:0] load_data;
    logic [31:0] ret_pc;
    logic [2:0]  ret_flags;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  w_vec;
    assign w_vec = {memory_read, memory_write, memory_push, memory_pop,
                    stall, load_valid, pc_valid, flags_valid};

    always #5 clk = ~clk;

    mem_access_sequencer #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .PC_W        (32),
        .FLAG_W      (3),
        .STACK_DEPTH (C_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .op_addr      (op_addr),
        .op_wdata     (op_wdata),
        .op_pc        (op_pc),
        .op_flags     (op_flags),
        .data_r       (data_r),
        .memory_read  (memory_read),
        .memory_write (memory_write),
        .memory_push  (memory_push),
        .memory_pop   (memory_pop),
        .address      (address),
        .write_data   (write_data),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .pc_valid     (pc_valid),
        .ret_pc       (ret_pc),
        .flags_valid  (flags_valid),
        .ret_flags    (ret_flags),
        .stack_err    (stack_err)
    );

    // Memory-stage model: registered read data, word memory and a word stack.
    logic [15:0] mem [256];
    logic [15:0] stk [16];
    logic [3:0]  sp;

    always @(posedge clk) begin
        if (reset) begin
            data_r <= 16'h0000;
            sp     <= 4'd0;
        end else begin
            if (memory_read)  data_r <= mem[address[7:0]];
            if (memory_write) mem[address[7:0]] <= write_data;
            if (memory_push) begin
                stk[sp] <= write_data;
                sp      <= sp + 4'd1;
            end
            if (memory_pop) begin
                data_r <= stk[sp - 4'd1];
                sp     <= sp - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, apply inputs, let outputs settle.
    task automatic cyc(input logic [3:0] o, input logic [15:0] a, input logic [15:0] d,
                       input logic [31:0] pc, input logic [2:0] fl);
        @(posedge clk);
        #1;
        op       = o;
        op_addr  = a;
        op_wdata = d;
        op_pc    = pc;
        op_flags = fl;
        #1;
    endtask

    task automatic idle();
        cyc(4'd0, 16'h0, 16'h0, 32'h0, 3'b0);
    endtask

    initial begin
        reset    = 1'b1;
        op       = 4'd0;
        op_addr  = 16'h0;
        op_wdata = 16'h0;
        op_pc    = 32'h0;
        op_flags = 3'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_vec", {24'h0, w_vec}, 32'h0);
        check("reset_err", {31'h0, stack_err}, 32'h0);
        check("reset_pc",  ret_pc, 32'h0);

`ifdef MEM_SEQ_STACK_GUARD_EN
        cyc(4'd3, 16'h0, 16'h00AA, 32'h0, 3'b0);
        check("g_push_vec", {24'h0, w_vec}, {24'h0, V_PU});
        cyc(4'd5, 16'h0, 16'h0, 32'h0001_2345, 3'b0);
        check("g_call_vec", {24'h0, w_vec}, 32'h0);
        idle();
        check("g_call_err", {31'h0, stack_err}, 32'h1);
        check("g_call_vec2", {24'h0, w_vec}, 32'h0);
        cyc(4'd4, 16'h0, 16'h0, 32'h0, 3'b0);
        check("g_pop_vec", {24'h0, w_vec}, {24'h0, V_PO});
        idle();
        check("g_pop_lv", {24'h0, w_vec}, {24'h0, V_LV});
        check("g_pop_data", {16'h0, load_data}, 32'h0000_00AA);
        check("g_err_sticky", {31'h0, stack_err}, 32'h1);
`else
        // STORE then LOAD
        cyc(4'd2, 16'h0010, 16'hBEEF, 32'h0, 3'b0);
        check("store_vec",  {24'h0, w_vec}, {24'h0, V_WR});
        check("store_addr", {16'h0, address}, 32'h10);
        check("store_wd",   {16'h0, write_data}, 32'hBEEF);
        cyc(4'd1, 16'h0010, 16'h0, 32'h0, 3'b0);
        check("load_vec",   {24'h0, w_vec}, {24'h0, V_RD});
        check("load_addr",  {16'h0, address}, 32'h10);
        idle();
        check("load_lv",    {24'h0, w_vec}, {24'h0, V_LV});
        check("load_data",  {16'h0, load_data}, 32'hBEEF);

        // CALL with op changed to STORE in cycle1
        cyc(4'd5, 16'h0, 16'h0, 32'h0001_2345, 3'b0);
        check("call_c0_vec", {24'h0, w_vec}, {24'h0, V_PU | V_ST});
        check("call_c0_wd",  {16'h0, write_data}, 32'h0001);
        cyc(4'd2, 16'h0055, 16'h1111, 32'h0, 3'b0);
        check("call_c1_vec", {24'h0, w_vec}, {24'h0, V_PU});
        check("call_c1_wd",  {16'h0, write_data}, 32'h2345);
        check("call_c1_adr", {16'h0, address}, 32'h0);
        idle();
        check("call_c2_vec", {24'h0, w_vec}, 32'h0);

        // RET
        cyc(4'd6, 16'h0, 16'h0, 32'h0, 3'b0);
        check("ret_c0_vec", {24'h0, w_vec}, {24'h0, V_PO | V_ST});
        cyc(4'd6, 16'h0, 16'h0, 32'h0, 3'b0);
        check("ret_c1_vec", {24'h0, w_vec}, {24'h0, V_PO | V_ST});
        cyc(4'd6, 16'h0, 16'h0, 32'h0, 3'b0);
        check("ret_c2_vec", {24'h0, w_vec}, {24'h0, V_PC});
        check("ret_c2_pc",  ret_pc, 32'h0001_2345);
        idle();
        check("ret_c3_vec", {24'h0, w_vec}, 32'h0);

        // INT then RTI
        cyc(4'd7, 16'h0, 16'h0, 32'hAAAA_5555, 3'b101);
        check("int_c0_vec", {24'h0, w_vec}, {24'h0, V_PU | V_ST});
        check("int_c0_wd",  {16'h0, write_data}, 32'hAAAA);
        cyc(4'd7, 16'h0, 16'h0, 32'hAAAA_5555, 3'b101);
        check("int_c1_vec", {24'h0, w_vec}, {24'h0, V_PU | V_ST});
        check("int_c1_wd",  {16'h0, write_data}, 32'h5555);
        cyc(4'd7, 16'h0, 16'h0, 32'hAAAA_5555, 3'b101);
        check("int_c2_vec", {24'h0, w_vec}, {24'h0, V_PU});
        check("int_c2_wd",  {16'h0, write_data}, 32'h0005);
        idle();
        check("int_c3_vec", {24'h0, w_vec}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'd8, 16'h0, 16'h0, 32'h0, 3'b0);
            check($sformatf("rti_c%0d_vec", i), {24'h0, w_vec}, {24'h0, V_PO | V_ST});
        end
        cyc(4'd8, 16'h0, 16'h0, 32'h0, 3'b0);
        check("rti_c3_vec",   {24'h0, w_vec}, {24'h0, V_PC | V_FV});
        check("rti_c3_pc",    ret_pc, 32'hAAAA_5555);
        check("rti_c3_flags", {29'h0, ret_flags}, 32'h5);
        idle();
        check("rti_c4_vec", {24'h0, w_vec}, 32'h0);

        // Single-word PUSH/POP and an unused op code
        cyc(4'd3, 16'h0, 16'h1234, 32'h0, 3'b0);
        check("push_vec", {24'h0, w_vec}, {24'h0, V_PU});
        check("push_wd",  {16'h0, write_data}, 32'h1234);
        cyc(4'd4, 16'h0, 16'h0, 32'h0, 3'b0);
        check("pop_vec",  {24'h0, w_vec}, {24'h0, V_PO});
        cyc(4'd9, 16'h0077, 16'h9999, 32'h0, 3'b0);
        check("pop_lv",   {24'h0, w_vec}, {24'h0, V_LV});
        check("pop_data", {16'h0, load_data}, 32'h1234);
        check("op9_adr",  {16'h0, address}, 32'h0);

        // Reset in cycle1 of RTI aborts the sequence
        cyc(4'd8, 16'h0, 16'h0, 32'h0, 3'b0);
        check("abort_c0_vec", {24'h0, w_vec}, {24'h0, V_PO | V_ST});
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_rst_vec", {24'h0, w_vec}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op    = 4'd0;
        #1;
        check("abort_c2_vec", {24'h0, w_vec}, 32'h0);
        check("abort_c2_pc",  ret_pc, 32'h0);
        check("abort_c2_ld",  {16'h0, load_data}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check($sformatf("abort_post%0d_vec", i), {24'h0, w_vec}, 32'h0);
        end
        check("err_tied", {31'h0, stack_err}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Initiator side of the memory-stage request interface: converts one pipeline memory op per request into the read/write/push/pop strobe sequence the memory stage consumes.
- Splits multi-word stack ops (CALL, RET, INT, RTI) into 16-bit word transfers, stalls the pipeline while sequencing, and reassembles popped words into a return PC and flags.
- Sits between the EX/MEM pipeline register and the memory stage.

Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 16, data address width
- PC_W, 32, program counter width (2 words)
- FLAG_W, 3, flag bits saved by INT/RTI (zero-extended to one word)
- STACK_DEPTH, 2048, stack capacity in words (guard feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op  in  4  memory op code (mem_seq_pkg encoding); must be held stable while stall=1
- op_addr  in  ADDR_W  address for LOAD/STORE
- op_wdata  in  DATA_W  data for STORE/PUSH
- op_pc  in  PC_W  PC to save for CALL/INT
- op_flags  in  FLAG_W  flags to save for INT
- data_r  in  DATA_W  registered read data from the memory stage; valid the cycle after a read/pop strobe
- memory_read, memory_write, memory_push, memory_pop  out  1 each  strobes to the memory stage
- address  out  ADDR_W  op_addr for LOAD/STORE, else 0
- write_data  out  DATA_W  word being written/pushed, else 0
- stall  out  1  hold upstream pipeline
- load_valid  out  1  load_data valid (LOAD/POP result)
- load_data  out  DATA_W  equals data_r
- pc_valid  out  1  ret_pc valid (RET/RTI)
- ret_pc  out  PC_W  reassembled PC
- flags_valid  out  1  ret_flags valid (RTI)
- ret_flags  out  FLAG_W  restored flags
- stack_err  out  1  sticky stack over/underflow (tied 0 without the feature)

Behaviour:
- Op codes: NONE=0, LOAD=1, STORE=2, PUSH=3, POP=4, CALL=5, RET=6, INT=7, RTI=8. Codes 9-15 are treated as NONE.
- States: IDLE, PUSH_SEQ, POP_SEQ, DRAIN. A 2-bit word counter cnt tracks the current word.
- Reset: state=IDLE, cnt=0, capture regs=0, all strobes/valids/stall=0, stack_err=0.
- IDLE: op is decoded combinationally and the first word is issued in the same cycle. Outside IDLE, op is ignored.
- Single-word ops complete in the IDLE cycle, with no stall:
  - LOAD: memory_read.
  - STORE: memory_write.
  - PUSH: memory_push, write_data=op_wdata.
  - POP: memory_pop.
  - LOAD/POP: load_valid pulses one cycle later.
- Push order and timing:
  - CALL pushes PC[31:16] then PC[15:0]. Cycle0 (IDLE, stall=1) pushes hi; cycle1 (PUSH_SEQ, stall=0) pushes lo.
  - INT pushes PC hi, PC lo, zero-extended flags in cycles 0, 1, 2. stall=1 in cycles 0-1 and 0 in cycle 2.
  - On the final push the state returns to IDLE.
  - The last word issues in the same cycle upstream advances.
- Pop order is the reverse of push order:
  - RET: pop in cycles 0-1. lo is captured from data_r in cycle1. Cycle2 (DRAIN): pc_valid=1, ret_pc={data_r, lo_q}.
  - RTI: pop in cycles 0-2. flags are captured in cycle1 and lo in cycle2. Cycle3 (DRAIN): pc_valid=flags_valid=1, ret_pc={data_r, lo_q}.
  - stall=1 in every pop cycle and 0 in DRAIN.
  - DRAIN always returns to IDLE; no new op is accepted during DRAIN.
- At most one strobe is high in any cycle. The sequencer never issues write and push together.
- Reset mid-sequence aborts immediately: no further strobes and no pc_valid. Words already pushed/popped are not compensated, because the memory stage stack pointer is not restored.

Optional Feature:
- Macro: MEM_SEQ_STACK_GUARD_EN.
- With the macro:
  - A depth counter (0..STACK_DEPTH) is incremented per push and decremented per pop.
  - At IDLE acceptance, an op is suppressed if depth+words > STACK_DEPTH (push ops) or depth < words (pop ops).
  - A suppressed op issues no strobes, takes no stall cycles, and produces no valid pulses; stack_err is set (sticky until reset).
- Without the macro: no counter; stack_err is constant 0.

Decomposition:
- mem_seq_pkg holds:
  - op code localparams
  - state encoding
  - per-op word counts: CALL/RET=2, INT/RTI=3, others 1
- Natural sub-module: mem_seq_stack_guard (depth counter plus check), instantiated only under MEM_SEQ_STACK_GUARD_EN.

Test Plan:
- STORE addr=0x0010 data=0xBEEF, then LOAD 0x0010 -> memory_write then memory_read with address 0x0010; load_valid next cycle with load_data=0xBEEF; stall never high.
- CALL pc=0x0001_2345, then RET -> pushes 0x0001 then 0x2345; stall high 1 cycle; RET pops twice; pc_valid in cycle2 with ret_pc=0x00012345.
- INT pc=0xAAAA_5555 flags=3'b101, then RTI -> 3 pushes; RTI pc_valid and flags_valid together in cycle3; ret_pc=0xAAAA5555, ret_flags=3'b101.
- Change op during CALL stall (op=STORE in cycle1) -> ignored; only the CALL push strobes appear.
- Reset asserted in cycle1 of RTI -> no further pop strobes; pc_valid never asserts; next-cycle state IDLE, all outputs 0.
- (guard build) STACK_DEPTH=2: PUSH, then CALL -> CALL suppressed with no strobes and stack_err=1; a subsequent POP still executes.
